// File: rtl/sqrt_iter_core_if.sv
// sqrt_iter_core_if: start/done handshake bundle between the CPU-side register
// wrapper (master) and the square-root core (slave).
//   init      master -> slave  start request
//   radicand  master -> slave  WIDTH-bit operand
//   result    slave -> master  WIDTH/2-bit floor(sqrt(radicand))
//   busy      slave -> master  operation in progress
//   done      slave -> master  one-cycle completion pulse
//   rem       slave -> master  WIDTH/2+1-bit remainder (only with SQRT_REM_EN)
// Optional feature macro: SQRT_REM_EN.
interface sqrt_iter_core_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned N = WIDTH / 2;

    logic             init;
    logic [WIDTH-1:0] radicand;
    logic [N-1:0]     result;
    logic             busy;
    logic             done;
`ifdef SQRT_REM_EN
    logic [N:0]       rem;

    modport master (output init, output radicand,
                    input result, input busy, input done, input rem);
    modport slave  (input init, input radicand,
                    output result, output busy, output done, output rem);
`else
    modport master (output init, output radicand,
                    input result, input busy, input done);
    modport slave  (input init, input radicand,
                    output result, output busy, output done);
`endif
endinterface

// File: rtl/sqrt_iter_core.sv
// sqrt_iter_core: iterative integer square root, floor(sqrt(radicand)), using the
// restoring two-bits-per-step method (one result bit per SHIFT/SUB pair).
// Fixed latency: done is seen 2N+2 cycles after the accepting edge, N = WIDTH/2.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset, wins over init
//   bus  sqrt_iter_core_if slave modport (init, radicand, result, busy, done[, rem])
// Optional feature macro: SQRT_REM_EN adds the registered remainder output bus.rem.
module sqrt_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    sqrt_iter_core_if.slave bus
);
    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StShift = 3'd2,
        StSub   = 3'd3,
        StEnd   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [N+1:0]     rem_w_q;
    logic [N+1:0]     trial_q;
    logic [N-1:0]     root_q;
    logic [CW-1:0]    count_q;
    logic [N-1:0]     result_q;
`ifdef SQRT_REM_EN
    logic [N:0]       rem_q;
`endif

    logic             ge;
    logic [N+1:0]     rem_sub;
    logic [N-1:0]     root_next;

    assign ge        = (rem_w_q >= trial_q);
    assign rem_sub   = rem_w_q - trial_q;
    assign root_next = {root_q[N-2:0], ge};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.init) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: state_d = StSub;
            StSub:   state_d = (count_q == '0) ? StEnd : StShift;
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            StLoad, StShift, StSub: bus.busy = 1'b1;
            StEnd: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.result = result_q;
`ifdef SQRT_REM_EN
    assign bus.rem = rem_q;
`endif

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            rem_w_q  <= '0;
            trial_q  <= '0;
            root_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
`ifdef SQRT_REM_EN
            rem_q    <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.init) acc_q <= bus.radicand;
                end
                StLoad: begin
                    root_q  <= '0;
                    rem_w_q <= '0;
                    count_q <= CW'(N - 1);
                end
                StShift: begin
                    // Partial remainder is below 2^N here, so the top two bits drop safely
                    rem_w_q <= {rem_w_q[N-1:0], acc_q[WIDTH-1 -: 2]};
                    acc_q   <= {acc_q[WIDTH-3:0], 2'b00};
                    trial_q <= {root_q, 2'b01};
                end
                StSub: begin
                    if (ge) rem_w_q <= rem_sub;
                    root_q <= root_next;
                    if (count_q == '0) begin
                        // Final bit: publish so result is valid alongside done
                        result_q <= root_next;
`ifdef SQRT_REM_EN
                        rem_q    <= ge ? rem_sub[N:0] : rem_w_q[N:0];
`endif
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_iter_core.sv
module tb_sqrt_iter_core;
    typedef struct {
        logic [63:0] res;
        logic [63:0] rm;
        int          acc_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   edges;
    int   busy_run32;
    int   busy_run8;
    exp_t q32[$];
    exp_t q8[$];

    sqrt_iter_core_if #(.WIDTH(32)) b32 ();
    sqrt_iter_core_if #(.WIDTH(8))  b8 ();

    sqrt_iter_core #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    sqrt_iter_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitors: pop the expected entry whenever a DUT pulses done
    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_run32 = 0;
        else if (b32.busy) busy_run32++;
        else busy_run32 = 0;
        if (b32.done) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check("result32", 64'(b32.result), e.res);
`ifdef SQRT_REM_EN
                check("rem32", 64'(b32.rem), e.rm);
`endif
                check("latency32", 64'(edges - e.acc_edge + 1), 64'd34);
                check("busy_len32", 64'(busy_run32), 64'd34);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_run8 = 0;
        else if (b8.busy) busy_run8++;
        else busy_run8 = 0;
        if (b8.done) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check("result8", 64'(b8.result), e.res);
`ifdef SQRT_REM_EN
                check("rem8", 64'(b8.rem), e.rm);
`endif
                check("latency8", 64'(edges - e.acc_edge + 1), 64'd10);
                check("busy_len8", 64'(busy_run8), 64'd10);
            end
        end
    end

    // Called at a negedge; waits for IDLE so the next edge accepts init
    task automatic issue(input bit sel8, input logic [31:0] rad, input logic [63:0] res,
                         input logic [63:0] rm, input bit push);
        int n;
        exp_t e;
        n = 0;
        while ((sel8 ? b8.busy : b32.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sel8 ? b8.busy : b32.busy) check("idle_timeout", 64'd1, 64'd0);
        e.res = res;
        e.rm = rm;
        e.acc_edge = edges + 1;
        if (sel8) begin
            b8.radicand = rad[7:0];
            b8.init = 1'b1;
            if (push) q8.push_back(e);
        end else begin
            b32.radicand = rad;
            b32.init = 1'b1;
            if (push) q32.push_back(e);
        end
        @(negedge clk);
        b8.init = 1'b0;
        b32.init = 1'b0;
    endtask

    initial begin
        int n;
        exp_t e;
        checks = 0;
        failures = 0;
        busy_run32 = 0;
        busy_run8 = 0;
        rst = 1'b1;
        b32.init = 1'b0;
        b32.radicand = '0;
        b8.init = 1'b0;
        b8.radicand = '0;
        repeat (3) @(negedge clk);
        check("rst_busy32", 64'(b32.busy), 64'd0);
        check("rst_done32", 64'(b32.done), 64'd0);
        check("rst_result32", 64'(b32.result), 64'd0);
        check("rst_busy8", 64'(b8.busy), 64'd0);
        check("rst_result8", 64'(b8.result), 64'd0);
`ifdef SQRT_REM_EN
        check("rst_rem32", 64'(b32.rem), 64'd0);
`endif
        // init asserted during reset must not start anything
        b32.init = 1'b1;
        @(negedge clk);
        b32.init = 1'b0;
        check("rst_wins_init", 64'(b32.busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 32'd0,          64'd0,     64'd0,      1'b1);
        issue(1'b0, 32'd144,        64'd12,    64'd0,      1'b1);
        issue(1'b0, 32'd15,         64'd3,     64'd6,      1'b1);
        issue(1'b0, 32'hFFFF_FFFF,  64'd65535, 64'd131070, 1'b1);
        issue(1'b0, 32'd1,          64'd1,     64'd0,      1'b1);
        issue(1'b0, 32'd2,          64'd1,     64'd1,      1'b1);
        issue(1'b0, 32'd99,         64'd9,     64'd18,     1'b1);
        issue(1'b0, 32'd1000000,    64'd1000,  64'd0,      1'b1);

        issue(1'b1, 32'd200, 64'd14, 64'd4,  1'b1);
        issue(1'b1, 32'd255, 64'd15, 64'd30, 1'b1);
        issue(1'b1, 32'd0,   64'd0,  64'd0,  1'b1);
        issue(1'b1, 32'd16,  64'd4,  64'd0,  1'b1);

        // Held init on the 8-bit core: exactly two back-to-back ops, 2N+3 = 11 edges apart
        n = 0;
        while (b8.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        b8.radicand = 8'd50;
        b8.init = 1'b1;
        e.res = 64'd7;
        e.rm = 64'd1;
        e.acc_edge = edges + 1;
        q8.push_back(e);
        e.acc_edge = edges + 12;
        q8.push_back(e);
        repeat (12) @(negedge clk);
        b8.init = 1'b0;

        // init and radicand changes while busy are ignored
        issue(1'b0, 32'd144, 64'd12, 64'd0, 1'b1);
        repeat (4) @(negedge clk);
        b32.radicand = 32'd81;
        b32.init = 1'b1;
        @(negedge clk);
        b32.init = 1'b0;
        b32.radicand = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        b32.radicand = 32'd7;

        // Reset mid-operation: abort, no done, result cleared
        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        issue(1'b0, 32'd1000, 64'd31, 64'd39, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(b32.busy), 64'd0);
        check("abort_done", 64'(b32.done), 64'd0);
        check("abort_result", 64'(b32.result), 64'd0);
`ifdef SQRT_REM_EN
        check("abort_rem", 64'(b32.rem), 64'd0);
`endif
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 64'(b32.busy), 64'd0);
        issue(1'b0, 32'd49, 64'd7, 64'd0, 1'b1);

        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", 64'(q8.size() + q32.size()), 64'd0);
        @(negedge clk);
        check("result_held", 64'(b32.result), 64'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
